id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 40 ++++
 rtl/id_ex_stage_hazard_detect.sv | 48 ++++
 rtl/id_ex_stage.sv | 129 ++++++++++++
 tb/tb_id_ex_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions: control-bundle layout, ALUOp encodings and default
// datapath/register-specifier widths used by the ID/EX stage.
package id_ex_stage_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_AW = 5;
   localparam int CTRL_W     = 9;

   // Bit positions of the control bundle, MSB first
   localparam int CTRL_REG_WRITE  = 8;
   localparam int CTRL_MEM_TO_REG = 7;
   localparam int CTRL_MEM_READ   = 6;
   localparam int CTRL_MEM_WRITE  = 5;
   localparam int CTRL_BRANCH     = 4;
   localparam int CTRL_ALU_SRC    = 3;
   localparam int CTRL_REG_DST    = 2;
   localparam int CTRL_ALU_OP_HI  = 1;
   localparam int CTRL_ALU_OP_LO  = 0;

   typedef enum logic [1:0] {
      ALU_OP_ADD    = 2'b00,
      ALU_OP_BRANCH = 2'b01,
      ALU_OP_FUNCT  = 2'b10,
      ALU_OP_RSVD   = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_to_reg;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      logic    alu_src;
      logic    reg_dst;
      alu_op_e alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = ctrl_t'(9'b0_0000_0000);

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detector: stalls PC and IF/ID while a load in
// EX writes a register the decoding instruction reads; a flush overrides it.
import id_ex_stage_pkg::*;

module hazard_detect #(
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              flush,
   output logic              hazard,
   output logic              pc_write,
   output logic              if_id_write
);

   logic load_in_ex_s;
   logic src_match_s;

   // Rt is compared even for I-type consumers; Rd never participates
   always_comb begin
      load_in_ex_s = ex_valid && ex_mem_read && (ex_rt != {REG_AW{1'b0}});
      src_match_s  = (ex_rt == id_rs) || (ex_rt == id_rt);
      if (load_in_ex_s && id_valid && src_match_s) begin
         hazard = 1'b1;
      end else begin
         hazard = 1'b0;
      end
   end

   // Front-end enables: a squash must let the PC redirect through
   always_comb begin
      if (flush) begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
      end else if (hazard) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end else begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and a
// saturating count of inserted load-use bubbles.
import id_ex_stage_pkg::*;

module id_ex_stage #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  ctrl_t             id_ctrl,
   input  logic [DATA_W-1:0] id_rdata1,
   input  logic [DATA_W-1:0] id_rdata2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              flush,
   output logic              ex_valid,
   output ctrl_t             ex_ctrl,
   output logic [DATA_W-1:0] ex_rdata1,
   output logic [DATA_W-1:0] ex_rdata2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic              pc_write,
   output logic              if_id_write,
   output logic [15:0]       stall_cnt
);

   logic              ex_valid_r;
   ctrl_t             ex_ctrl_r;
   logic [DATA_W-1:0] ex_rdata1_r;
   logic [DATA_W-1:0] ex_rdata2_r;
   logic [DATA_W-1:0] ex_imm_r;
   logic [DATA_W-1:0] ex_pc4_r;
   logic [REG_AW-1:0] ex_rs_r;
   logic [REG_AW-1:0] ex_rt_r;
   logic [REG_AW-1:0] ex_rd_r;
   logic [15:0]       stall_cnt_r;
   logic              hazard_s;
   logic              bubble_s;
   logic              count_s;

   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard_detect (
      .ex_valid    (ex_valid_r),
      .ex_mem_read (ex_ctrl_r.mem_read),
      .ex_rt       (ex_rt_r),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .flush       (flush),
      .hazard      (hazard_s),
      .pc_write    (pc_write),
      .if_id_write (if_id_write)
   );

   // Bubble and bubble-count qualifiers
   always_comb begin
      bubble_s = flush || hazard_s;
      if (hazard_s && !flush && (stall_cnt_r != 16'hFFFF)) begin
         count_s = 1'b1;
      end else begin
         count_s = 1'b0;
      end
   end

   // Valid/control half of the register: bubbles clear it, idle slots carry no control
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_r <= 1'b0;
         ex_ctrl_r  <= CTRL_NOP;
      end else if (bubble_s) begin
         ex_valid_r <= 1'b0;
         ex_ctrl_r  <= CTRL_NOP;
      end else begin
         ex_valid_r <= id_valid;
         ex_ctrl_r  <= id_valid ? id_ctrl : CTRL_NOP;
      end
   end

   // Data/specifier half: held across bubbles so only the control is squashed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_rdata1_r <= {DATA_W{1'b0}};
         ex_rdata2_r <= {DATA_W{1'b0}};
         ex_imm_r    <= {DATA_W{1'b0}};
         ex_pc4_r    <= {DATA_W{1'b0}};
         ex_rs_r     <= {REG_AW{1'b0}};
         ex_rt_r     <= {REG_AW{1'b0}};
         ex_rd_r     <= {REG_AW{1'b0}};
      end else if (!bubble_s) begin
         ex_rdata1_r <= id_rdata1;
         ex_rdata2_r <= id_rdata2;
         ex_imm_r    <= id_imm;
         ex_pc4_r    <= id_pc4;
         ex_rs_r     <= id_rs;
         ex_rt_r     <= id_rt;
         ex_rd_r     <= id_rd;
      end
   end

   // Saturating load-use bubble counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= 16'h0000;
      end else if (count_s) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end
   end

   assign ex_valid  = ex_valid_r;
   assign ex_ctrl   = ex_ctrl_r;
   assign ex_rdata1 = ex_rdata1_r;
   assign ex_rdata2 = ex_rdata2_r;
   assign ex_imm    = ex_imm_r;
   assign ex_pc4    = ex_pc4_r;
   assign ex_rs     = ex_rs_r;
   assign ex_rt     = ex_rt_r;
   assign ex_rd     = ex_rd_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push hand-computed
// expected outputs; a monitor pops and compares them on each falling edge.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [8:0]  id_ctrl = 9'h000;
   logic [31:0] id_rdata1 = 32'h0, id_rdata2 = 32'h0, id_imm = 32'h0, id_pc4 = 32'h0;
   logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
   logic        flush = 1'b0;
   logic        ex_valid;
   logic [8:0]  ex_ctrl;
   logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic        pc_write, if_id_write;
   logic [15:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       nm;
      logic        v;
      logic [8:0]  ctrl;
      logic [31:0] d1, d2, imm, pc4;
      logic [4:0]  rs, rt, rd;
      logic [15:0] cnt;
      logic        pcw;
      logic        chkd;
   } exp_t;

   exp_t q[$];
   event mid_ev;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
      .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .pc_write(pc_write), .if_id_write(if_id_write), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic drv(input logic v, input logic [8:0] c, input logic [4:0] rs, rt, rd,
                      input logic [31:0] d1, d2, imm, pc4, input logic fl);
      id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_pc4 = pc4; flush = fl;
   endtask

   task automatic expect_out(input string nm, input logic v, input logic [8:0] c,
                             input logic [31:0] d1, d2, imm, pc4, input logic [4:0] rs, rt, rd,
                             input logic [15:0] cnt, input logic pcw, input logic chkd);
      exp_t e;
      e.nm = nm; e.v = v; e.ctrl = c; e.d1 = d1; e.d2 = d2; e.imm = imm; e.pc4 = pc4;
      e.rs = rs; e.rt = rt; e.rd = rd; e.cnt = cnt; e.pcw = pcw; e.chkd = chkd;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the DUT outputs against the oldest expectation
   initial begin
      exp_t e;
      logic [170:0] act, req, msk;
      forever begin
         @(negedge clk or mid_ev);
         if (q.size() > 0) begin
            e = q.pop_front();
            msk = {1'b1, 9'h1FF, {143{e.chkd}}, 16'hFFFF, 2'b11};
            act = {ex_valid, ex_ctrl, ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
                   ex_rs, ex_rt, ex_rd, stall_cnt, pc_write, if_id_write} & msk;
            req = {e.v, e.ctrl, e.d1, e.d2, e.imm, e.pc4,
                   e.rs, e.rt, e.rd, e.cnt, e.pcw, e.pcw} & msk;
            n_tests++;
            if (act !== req) begin
               n_fail++;
               $display("FAIL %s: got v=%b ctrl=%h d1=%h d2=%h imm=%h pc4=%h rs=%0d rt=%0d rd=%0d cnt=%h pcw=%b ifw=%b ; required v=%b ctrl=%h d1=%h d2=%h imm=%h pc4=%h rs=%0d rt=%0d rd=%0d cnt=%h pcw=%b ifw=%b",
                        e.nm, ex_valid, ex_ctrl, ex_rdata1, ex_rdata2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
                        stall_cnt, pc_write, if_id_write, e.v, e.ctrl, e.d1, e.d2, e.imm, e.pc4,
                        e.rs, e.rt, e.rd, e.cnt, e.pcw, e.pcw);
            end
         end
      end
   end

   // Stimulus: LW = 9'h1C8, R-type = 9'h106, I-type ALU = 9'h108
   initial begin
      tick();
      expect_out("reset_state", 1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1, 1'b1);
      tick(); rst = 1'b0;
      drv(1'b1, 9'h106, 5'd3, 5'd4, 5'd2, 32'h11, 32'h22, 32'h33, 32'h104, 1'b0);
      expect_out("post_reset_idle", 1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h1C8, 5'd1, 5'd5, 5'd0, 32'h1000, 32'h0, 32'h8, 32'h108, 1'b0);
      expect_out("normal_flow", 1'b1, 9'h106, 32'h11, 32'h22, 32'h33, 32'h104, 5'd3, 5'd4, 5'd2, 16'h0000, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h106, 5'd5, 5'd6, 5'd7, 32'h55, 32'h66, 32'h77, 32'h10C, 1'b0);
      expect_out("load_use_stall", 1'b1, 9'h1C8, 32'h1000, 32'h0, 32'h8, 32'h108, 5'd1, 5'd5, 5'd0, 16'h0000, 1'b0, 1'b1);
      tick();
      expect_out("load_use_bubble", 1'b0, 9'h000, 32'h1000, 32'h0, 32'h8, 32'h108, 5'd1, 5'd5, 5'd0, 16'h0001, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h106, 5'd8, 5'd9, 5'd10, 32'h88, 32'h99, 32'hAA, 32'h110, 1'b0);
      expect_out("held_insn_proceeds", 1'b1, 9'h106, 32'h55, 32'h66, 32'h77, 32'h10C, 5'd5, 5'd6, 5'd7, 16'h0001, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h1C8, 5'd2, 5'd0, 5'd0, 32'h200, 32'h0, 32'h4, 32'h114, 1'b0);
      expect_out("capture_after_stall", 1'b1, 9'h106, 32'h88, 32'h99, 32'hAA, 32'h110, 5'd8, 5'd9, 5'd10, 16'h0001, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h106, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 32'h118, 1'b0);
      expect_out("zero_reg_no_stall", 1'b1, 9'h1C8, 32'h200, 32'h0, 32'h4, 32'h114, 5'd2, 5'd0, 5'd0, 16'h0001, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h1C8, 5'd1, 5'd7, 5'd0, 32'h300, 32'h0, 32'hC, 32'h11C, 1'b0);
      expect_out("zero_reg_captured", 1'b1, 9'h106, 32'h0, 32'h0, 32'h0, 32'h118, 5'd0, 5'd0, 5'd3, 16'h0001, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h108, 5'd2, 5'd7, 5'd7, 32'h400, 32'h500, 32'h10, 32'h120, 1'b1);
      expect_out("flush_over_hazard", 1'b1, 9'h1C8, 32'h300, 32'h0, 32'hC, 32'h11C, 5'd1, 5'd7, 5'd0, 16'h0001, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h106, 5'd4, 5'd4, 5'd4, 32'h44, 32'h45, 32'h46, 32'h124, 1'b0);
      expect_out("flush_bubble", 1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0001, 1'b1, 1'b0);
      tick();
      drv(1'b0, 9'h1C8, 5'd4, 5'd5, 5'd6, 32'h66, 32'h67, 32'h68, 32'h128, 1'b0);
      expect_out("capture_after_flush", 1'b1, 9'h106, 32'h44, 32'h45, 32'h46, 32'h124, 5'd4, 5'd4, 5'd4, 16'h0001, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h1C8, 5'd1, 5'd9, 5'd0, 32'h900, 32'h0, 32'h0, 32'h12C, 1'b0);
      expect_out("invalid_ctrl_forced", 1'b0, 9'h000, 32'h66, 32'h67, 32'h68, 32'h128, 5'd4, 5'd5, 5'd6, 16'h0001, 1'b1, 1'b1);
      tick();
      drv(1'b0, 9'h000, 5'd9, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0, 32'h130, 1'b0);
      expect_out("invalid_consumer_no_stall", 1'b1, 9'h1C8, 32'h900, 32'h0, 32'h0, 32'h12C, 5'd1, 5'd9, 5'd0, 16'h0001, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h106, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 32'h134, 1'b0);
      expect_out("invalid_captured", 1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 32'h130, 5'd9, 5'd9, 5'd0, 16'h0001, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h1C8, 5'd0, 5'd5, 5'd0, 32'hA0, 32'h0, 32'h0, 32'h138, 1'b0);
      expect_out("pre_saturation", 1'b1, 9'h106, 32'h1, 32'h2, 32'h3, 32'h134, 5'd1, 5'd2, 5'd3, 16'h0001, 1'b1, 1'b1);
      @(negedge clk); #1;
      force dut.stall_cnt_r = 16'hFFFE;
      #1;
      release dut.stall_cnt_r;
      tick();
      drv(1'b1, 9'h106, 5'd5, 5'd0, 5'd1, 32'hB0, 32'hB1, 32'hB2, 32'h13C, 1'b0);
      expect_out("sat_hazard1", 1'b1, 9'h1C8, 32'hA0, 32'h0, 32'h0, 32'h138, 5'd0, 5'd5, 5'd0, 16'hFFFE, 1'b0, 1'b1);
      tick();
      expect_out("sat_reach_max", 1'b0, 9'h000, 32'hA0, 32'h0, 32'h0, 32'h138, 5'd0, 5'd5, 5'd0, 16'hFFFF, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h1C8, 5'd0, 5'd5, 5'd0, 32'hC0, 32'h0, 32'h0, 32'h140, 1'b0);
      expect_out("sat_capture", 1'b1, 9'h106, 32'hB0, 32'hB1, 32'hB2, 32'h13C, 5'd5, 5'd0, 5'd1, 16'hFFFF, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h106, 5'd0, 5'd5, 5'd1, 32'hD0, 32'hD1, 32'hD2, 32'h144, 1'b0);
      expect_out("rt_match_hazard", 1'b1, 9'h1C8, 32'hC0, 32'h0, 32'h0, 32'h140, 5'd0, 5'd5, 5'd0, 16'hFFFF, 1'b0, 1'b1);
      tick();
      expect_out("sat_stays_max", 1'b0, 9'h000, 32'hC0, 32'h0, 32'h0, 32'h140, 5'd0, 5'd5, 5'd0, 16'hFFFF, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h1C8, 5'd0, 5'd6, 5'd0, 32'hE0, 32'h0, 32'h0, 32'h148, 1'b0);
      expect_out("pre_reset_flow", 1'b1, 9'h106, 32'hD0, 32'hD1, 32'hD2, 32'h144, 5'd0, 5'd5, 5'd1, 16'hFFFF, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h106, 5'd6, 5'd0, 5'd2, 32'hF0, 32'hF1, 32'hF2, 32'h14C, 1'b0);
      expect_out("stall_before_reset", 1'b1, 9'h1C8, 32'hE0, 32'h0, 32'h0, 32'h148, 5'd0, 5'd6, 5'd0, 16'hFFFF, 1'b0, 1'b1);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      expect_out("async_reset_mid_stall", 1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1, 1'b1);
      -> mid_ev;
      tick(); rst = 1'b0;
      expect_out("reset_held_edge", 1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1, 1'b1);
      tick();
      drv(1'b1, 9'h106, 5'd1, 5'd1, 5'd1, 32'h11, 32'h12, 32'h13, 32'h200, 1'b0);
      expect_out("post_reset_capture", 1'b1, 9'h106, 32'hF0, 32'hF1, 32'hF2, 32'h14C, 5'd6, 5'd0, 5'd2, 16'h0000, 1'b1, 1'b1);
      tick();
      drv(1'b0, 9'h000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      expect_out("final_flow", 1'b1, 9'h106, 32'h11, 32'h12, 32'h13, 32'h200, 5'd1, 5'd1, 5'd1, 16'h0000, 1'b1, 1'b1);
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      #2;
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
